md_issue_ctrl: RTL
==================

// Module: md_issue_ctrl
// PURPOSE
//  Issue side of the multiply/divide unit. Sits between the D and E stages.
//  Owns the E-stage MD op register that drives the unit's op input.
//  Tracks each in-flight MULT/MULTU/DIV/DIVU with its own latency counter and
//  stalls D while an MD op runs. This covers the issue cycle, where the unit's
//  busy flag has not yet risen.
// PARAMETERS
//  MUL_CYC  5   cycles md_busy stays high after a MULT/MULTU start edge
//  DIV_CYC  10  cycles md_busy stays high after a DIV/DIVU start edge
// PORTS
//  clk        in   1  clock; all state changes on the rising edge
//  reset      in   1  asynchronous, active-low reset
//  d_md_req   in   1  the D-stage instruction is MD-class (mult/div/mthi/mtlo/mfhi/mflo)
//  d_md_op    in   3  unit op for that instruction; MD_NONE for mfhi/mflo
//  stall_ext  in   1  stall request from the rest of the hazard unit
//  md_busy    in   1  busy flag returned by the multiply/divide unit
//  md_e_op    out  3  registered E-stage op, wired to the unit's op input
//  stall_d    out  1  freezes PC/IF-ID and bubbles ID-EX (MD hazard only)
//  md_err     out  1  sticky latency-mismatch flag (MD_LAT_CHECK_EN)
// BEHAVIOUR
//  Reset (reset=0, async)
//   - state=IDLE, cnt=0, md_e_op=MD_NONE, md_err=0.
//   - stall_d is combinational and reads 0 while reset is held.
//  Start op: MD_MULT, MD_MULTU, MD_DIV or MD_DIVU. MD_MTHI/MD_MTLO are never start ops.
//  Stall rule
//   - stall_d = d_md_req && (state!=IDLE || md_busy).
//   - Non-MD instructions are never stalled by this block.
//  E register, updated every edge
//   - md_e_op <= (stall_d || stall_ext || !d_md_req) ? MD_NONE : d_md_op.
//   - An op is presented to the unit for exactly one cycle.
//  FSM
//   - IDLE -> ISSUE: on an edge that loads a start op into md_e_op.
//   - ISSUE -> RUN: next edge (the unit latches here). cnt <= CYC-1, where CYC
//     is MUL_CYC or DIV_CYC, chosen from md_e_op.
//   - RUN: cnt decrements each edge. At cnt==0 the next state is IDLE.
//   - RUN therefore lasts exactly CYC cycles and mirrors md_busy.
//   - HI/LO are valid in the first IDLE cycle.
//  Stall length: an MD instruction directly behind a start op stalls 1+CYC cycles
//   (6 after a multiply, 11 after a divide).
//  mthi/mtlo in E never stall; the unit writes HI/LO at the next edge, before
//   a following mfhi reaches E.
//  stall_ext only turns the E op into a bubble; it never advances or rewinds the FSM.
//  cnt width is $clog2(DIV_CYC) bits; it never wraps (loaded only in ISSUE).
//  Reset mid-op: everything clears at once. The unit shares this reset, so no op survives.
// CONFIGURATION
//  MD_LAT_CHECK_EN defined
//   - Each edge outside reset: if (state==RUN) != md_busy, md_err <= 1.
//   - md_err is sticky until reset.
//  MD_LAT_CHECK_EN undefined
//   - md_err is tied to 0 and the comparator is not built.
// STRUCTURE
//  Shared package md_pkg holds:
//   - op codes MD_NONE=0, MD_MTHI=1, MD_MTLO=2, MD_MULT=3, MD_MULTU=4,
//     MD_DIV=5, MD_DIVU=6;
//   - the FSM state encoding IDLE/ISSUE/RUN;
//   - the is_start(op) helper.
//  One sub-module is natural: md_cycle_cnt, a loadable down-counter with a
//   zero flag. The FSM and the E register stay in md_issue_ctrl.
// TESTING
//  1. Hold reset=0 for 3 cycles, then release -> md_e_op=0, stall_d=0, md_err=0, state IDLE.
//  2. MULT in D at cycle 0, MFHI in D at cycle 1 -> md_e_op=3 for one cycle;
//     stall_d=1 for 6 cycles; MFHI leaves D at cycle 7.
//  3. DIVU issued, then MTLO in D -> stall_d=1 for 11 cycles; md_e_op=2 one cycle later.
//  4. ADDU/LW stream during RUN (d_md_req=0) -> stall_d=0 every cycle; md_e_op=0.
//  5. stall_ext=1 for 2 cycles with MULT in D -> md_e_op=0 and state IDLE;
//     md_e_op=3 on the edge after stall_ext drops.
//  6. reset=0 mid-RUN (cnt=3) -> state IDLE, md_e_op=0 immediately. With
//     MD_LAT_CHECK_EN, a busy model that drops 2 cycles early -> md_err=1, sticky.

Source files
------------

// File: rtl/md_pkg.sv
// md_pkg: op codes, FSM states and helpers shared by the multiply/divide issue logic.
package md_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MTHI  = 3'd1,
        MD_MTLO  = 3'd2,
        MD_MULT  = 3'd3,
        MD_MULTU = 3'd4,
        MD_DIV   = 3'd5,
        MD_DIVU  = 3'd6
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RUN   = 2'd2
    } md_state_e;

    localparam int unsigned MD_MUL_CYC = 5;
    localparam int unsigned MD_DIV_CYC = 10;

    function automatic logic is_start(input logic [2:0] op);
        return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
    endfunction

    function automatic logic is_mul(input logic [2:0] op);
        return op inside {MD_MULT, MD_MULTU};
    endfunction

endpackage

// File: rtl/md_issue_ctrl_cnt.sv
// md_cycle_cnt: loadable down-counter with a zero flag; holds at zero instead of wrapping.
module md_cycle_cnt #(
    parameter int unsigned W = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = load_i ? load_val_i : (dec_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: D/E-stage issue control for the multiply/divide unit (E op register, stall, latency FSM).
// Optional MD_LAT_CHECK_EN builds a sticky RUN-vs-md_busy mismatch flag on md_err_o.
module md_issue_ctrl
    import md_pkg::*;
#(
    parameter int unsigned MUL_CYC = MD_MUL_CYC,
    parameter int unsigned DIV_CYC = MD_DIV_CYC
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       d_md_req_i,
    input  logic [2:0] d_md_op_i,
    input  logic       stall_ext_i,
    input  logic       md_busy_i,
    output logic [2:0] md_e_op_o,
    output logic       stall_d_o,
    output logic       md_err_o
);

    localparam int unsigned CW = $clog2(DIV_CYC);

    md_state_e     state_q, state_d;
    logic [2:0]    e_op_q, e_op_d;
    logic          cnt_load, cnt_zero;
    logic [CW-1:0] cnt_val;

    // ISSUE covers the cycle before the unit raises busy
    assign stall_d_o = rst_ni && d_md_req_i && (state_q != IDLE || md_busy_i);
    assign cnt_val   = is_mul(e_op_q) ? CW'(MUL_CYC - 1) : CW'(DIV_CYC - 1);

    always_comb begin
        e_op_d   = (stall_d_o || stall_ext_i || !d_md_req_i) ? MD_NONE : d_md_op_i;
        state_d  = state_q;
        cnt_load = 1'b0;
        unique case (state_q)
            IDLE:    state_d = is_start(e_op_d) ? ISSUE : IDLE;
            ISSUE: begin
                state_d  = RUN;
                cnt_load = 1'b1;
            end
            RUN:     state_d = cnt_zero ? IDLE : RUN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            e_op_q  <= MD_NONE;
        end else begin
            state_q <= state_d;
            e_op_q  <= e_op_d;
        end
    end

    md_cycle_cnt #(.W(CW)) u_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .dec_i      (state_q == RUN),
        .zero_o     (cnt_zero)
    );

    assign md_e_op_o = e_op_q;

`ifdef MD_LAT_CHECK_EN
    logic err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) err_q <= 1'b0;
        else         err_q <= err_q | ((state_q == RUN) != md_busy_i);
    end

    assign md_err_o = err_q;
`else
    assign md_err_o = 1'b0;
`endif

endmodule
